stn_cap_buf: RTL
================

STN_CAP_BUF -- requirements
Module: stn_cap_buf

Interface
REQ-001 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-002 SHALL have port rst_x  input  1  asynchronous active-low reset.
REQ-003 SHALL have port stn_fpframe  input  1  STN frame pulse, high active, asynchronous to clk.
REQ-004 SHALL have port stn_fpline  input  1  STN line pulse, high active, asynchronous.
REQ-005 SHALL have port stn_fpshift  input  1  STN data shift clock, data valid on falling edge, asynchronous.
REQ-006 SHALL have port stn_fd  input  4  STN pixel data nibble.
REQ-007 SHALL have port fifo_rdreq  input  1  display read request from the TFT timing generator.
REQ-008 SHALL have port fifo_rdack  output  1  read grant.
REQ-009 SHALL have port fifo_raddr  input  13  display read byte address.
REQ-010 SHALL have port fifo_rdata  output  8  display read data.
REQ-011 SHALL have port ram_addr  output  13  single-port frame RAM address.
REQ-012 SHALL have port ram_we  output  1  RAM write enable, high active.
REQ-013 SHALL have port ram_wdata  output  8  RAM write data.
REQ-014 SHALL have port ram_rdata  input  8  RAM read data, valid one clk after the address is presented.

Function
REQ-015 SHALL pass stn_fpframe, stn_fpline, stn_fpshift and stn_fd through 2-flop synchronizers plus one history flop each; edges are detected on synchronized stages 1/2.
REQ-016 SHALL latch synchronized stn_fd on each detected fpshift falling edge; the 1st nibble goes to byte bits [7:4], the 2nd to bits [3:0].
REQ-017 SHALL, on the 2nd nibble, load the assembled byte into wr_data and set wr_pend in the same cycle; nibble_sel toggles per shift edge.
REQ-018 SHALL clear nibble_sel on each fpline rising edge; a half-assembled byte is discarded.
REQ-019 SHALL reset wr_addr to 0 on an fpline rising edge while synchronized fpframe is high.
REQ-020 SHALL give reads priority: fifo_rdack = fifo_rdreq (combinational); ram_addr = fifo_raddr and ram_we = 0 whenever fifo_rdreq = 1.
REQ-021 SHALL, when fifo_rdreq = 0 and wr_pend = 1, drive ram_we = 1, ram_addr = wr_addr and ram_wdata = wr_data for one clk; on the next edge clear wr_pend and increment wr_addr.
REQ-022 SHALL wrap wr_addr from 13'h17BF to 13'h0000; the address never exceeds 13'h17BF.
REQ-023 SHALL drive fifo_rdata = ram_rdata directly; the requester samples it one clk after the grant.
REQ-024 SHALL, if a new byte completes while wr_pend = 1 and the pending write is not retiring that cycle, drop the new byte and leave wr_data, wr_addr and wr_pend unchanged.
REQ-025 SHALL treat a byte completing in the same cycle the pending write retires as a new pending write, with no drop.
REQ-026 SHALL, when a frame reset (REQ-019) coincides with a pending write, retire the pending byte at its old address, and write subsequent bytes from address 0.

Reset
REQ-027 SHALL, while rst_x = 0, clear all synchronizers, nibble_sel, wr_pend, wr_data and wr_addr, and drive ram_we = 0, ram_wdata = 8'h00 and ram_addr = fifo_raddr.
REQ-028 SHALL, after reset deassertion, ignore STN edges until the synchronizer history is valid (2 clks); no spurious edge is detected from reset values.

Configuration
REQ-029 SHALL, when macro STN_CAP_DROP_CNT_EN is defined, add output port cap_drop_cnt (8 bits, reset 8'h00), which increments on every REQ-024 drop, saturates at 8'hFF and clears on a frame reset.
REQ-030 SHALL, without STN_CAP_DROP_CNT_EN, have neither the port nor the counter; drop behaviour per REQ-024 is unchanged.

Verification
REQ-031 Shifts with nibbles 4'hA then 4'h5, rdreq = 0 -> exactly one ram_we pulse, wdata 8'hA5, addr 0; next byte goes to addr 1.
REQ-032 Frame pulse, then 6081 bytes -> the last byte is written at addr 0 (wrap after 13'h17BF).
REQ-033 rdreq held high, raddr = 13'h0123, RAM preloaded with 8'h3C -> rdack = 1 in the same clk, fifo_rdata = 8'h3C one clk later, no ram_we while rdreq is high.
REQ-034 rdreq held high across two completed bytes -> the first byte is written after rdreq drops, the second is dropped; with STN_CAP_DROP_CNT_EN, cap_drop_cnt = 1.
REQ-035 One nibble then an fpline edge, then nibbles 4'h1 and 4'h2 -> one write of 8'h12.
REQ-036 rst_x asserted mid-line with wr_pend = 1 -> ram_we = 0 immediately, no write after release, the next byte goes to addr 0.

Source files
------------

// File: rtl/stn_cap_buf.sv
// -----------------------------------------------------------------------------
// stn_cap_buf
//   Captures a 4-bit STN LCD pixel stream into a single-port frame RAM.
//   Incoming STN strobes are asynchronous to clk and are synchronised first.
//   Nibble pairs are assembled into bytes and written sequentially, with a
//   wrap after 13'h17BF. A TFT timing generator reads the same RAM and always
//   wins arbitration. A byte that completes while the previous byte is still
//   blocked by reads is dropped.
//
// Ports
//   clk           system clock, rising edge
//   rst_x         asynchronous active-low reset
//   stn_fpframe   STN frame pulse (async, high active)
//   stn_fpline    STN line pulse (async, high active)
//   stn_fpshift   STN shift clock, data valid on its falling edge (async)
//   stn_fd[3:0]   STN pixel nibble
//   fifo_rdreq    display read request
//   fifo_rdack    read grant, same cycle as the request
//   fifo_raddr    display read byte address
//   fifo_rdata    display read data (RAM data, one clk after the grant)
//   ram_addr      frame RAM address
//   ram_we        frame RAM write enable
//   ram_wdata     frame RAM write data
//   ram_rdata     frame RAM read data, one clk after the address
//   cap_drop_cnt  saturating count of dropped bytes (STN_CAP_DROP_CNT_EN only)
//
// Build option
//   STN_CAP_DROP_CNT_EN : adds cap_drop_cnt. Dropping bytes happens either way.
// -----------------------------------------------------------------------------
module stn_cap_buf (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        stn_fpframe,
  input  logic        stn_fpline,
  input  logic        stn_fpshift,
  input  logic [3:0]  stn_fd,
  input  logic        fifo_rdreq,
  output logic        fifo_rdack,
  input  logic [12:0] fifo_raddr,
  output logic [7:0]  fifo_rdata,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
`ifdef STN_CAP_DROP_CNT_EN
  ,
  output logic [7:0]  cap_drop_cnt
`endif
);

  localparam logic [12:0] LAST_ADDR = 13'h17BF;

  // Control strobes packed as {fpframe, fpline, fpshift}.
  logic [2:0]  r_ctl_s1;
  logic [2:0]  r_ctl_s2;
  logic [2:0]  r_ctl_h;
  logic [3:0]  r_fd_s1;
  logic [3:0]  r_fd_s2;
  logic [1:0]  r_arm;

  logic        r_nib_sel;
  logic [3:0]  r_nib_hi;
  logic        r_wr_pend;
  logic [7:0]  r_wr_data;
  logic [12:0] r_wr_addr;
  logic        r_addr_clr;

  logic        w_hist_vld;
  logic        w_shift_fall;
  logic        w_line_rise;
  logic        w_frame_rst;
  logic        w_byte_done;
  logic        w_retire;
  logic        w_accept;
  logic [12:0] w_next_addr;

  // Two-flop synchronisers plus one history stage per STN input.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_ctl_s1 <= 3'b000;
      r_ctl_s2 <= 3'b000;
      r_ctl_h  <= 3'b000;
      r_fd_s1  <= 4'h0;
      r_fd_s2  <= 4'h0;
    end else begin
      r_ctl_s1 <= {stn_fpframe, stn_fpline, stn_fpshift};
      r_ctl_s2 <= r_ctl_s1;
      r_ctl_h  <= r_ctl_s2;
      r_fd_s1  <= stn_fd;
      r_fd_s2  <= r_fd_s1;
    end
  end

  // Arming counter: edges are only trusted once the history stage holds a
  // sample taken after reset, so reset zeros never look like an edge.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_arm <= 2'd0;
    end else if (r_arm != 2'd3) begin
      r_arm <= r_arm + 2'd1;
    end
  end

  assign w_hist_vld   = (r_arm == 2'd3);
  assign w_shift_fall = w_hist_vld & ~r_ctl_s2[0] &  r_ctl_h[0];
  assign w_line_rise  = w_hist_vld &  r_ctl_s2[1] & ~r_ctl_h[1];
  // Frame level must be seen on two consecutive samples to count as high.
  assign w_frame_rst  = w_line_rise & r_ctl_s2[2] & r_ctl_h[2];

  // A line edge wins over a coincident shift edge: the half byte is lost.
  assign w_byte_done  = w_shift_fall & r_nib_sel & ~w_line_rise;
  assign w_retire     = r_wr_pend & ~fifo_rdreq;
  assign w_accept     = w_byte_done & (~r_wr_pend | w_retire);
  assign w_next_addr  = (r_wr_addr == LAST_ADDR) ? 13'h0000 : (r_wr_addr + 13'd1);

  // Nibble assembly: first nibble is the high half, the second completes the byte.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_nib_sel <= 1'b0;
      r_nib_hi  <= 4'h0;
    end else if (w_line_rise) begin
      r_nib_sel <= 1'b0;
    end else if (w_shift_fall) begin
      r_nib_sel <= ~r_nib_sel;
      if (!r_nib_sel) begin
        r_nib_hi <= r_fd_s2;
      end
    end
  end

  // Pending write holder; a byte completing while the holder is blocked is lost.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_wr_pend <= 1'b0;
      r_wr_data <= 8'h00;
    end else if (w_accept) begin
      r_wr_pend <= 1'b1;
      r_wr_data <= {r_nib_hi, r_fd_s2};
    end else if (w_retire) begin
      r_wr_pend <= 1'b0;
    end
  end

  // Write address. A frame reset seen while a byte is still pending is
  // remembered in r_addr_clr so that byte keeps its old address and the
  // address restarts at 0 only once it has been written.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_wr_addr  <= 13'h0000;
      r_addr_clr <= 1'b0;
    end else if (w_retire) begin
      r_wr_addr  <= (w_frame_rst | r_addr_clr) ? 13'h0000 : w_next_addr;
      r_addr_clr <= 1'b0;
    end else if (w_frame_rst) begin
      if (r_wr_pend) begin
        r_addr_clr <= 1'b1;
      end else begin
        r_wr_addr <= 13'h0000;
      end
    end
  end

`ifdef STN_CAP_DROP_CNT_EN
  logic w_drop;
  assign w_drop = w_byte_done & r_wr_pend & ~w_retire;

  // Saturating drop counter, cleared by each frame reset.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cap_drop_cnt <= 8'h00;
    end else if (w_frame_rst) begin
      cap_drop_cnt <= 8'h00;
    end else if (w_drop && (cap_drop_cnt != 8'hFF)) begin
      cap_drop_cnt <= cap_drop_cnt + 8'd1;
    end
  end
`endif

  // RAM port arbitration: reads always win; writes use idle cycles only.
  assign fifo_rdack = fifo_rdreq;
  assign fifo_rdata = ram_rdata;
  assign ram_we     = w_retire;
  assign ram_addr   = w_retire ? r_wr_addr : fifo_raddr;
  assign ram_wdata  = r_wr_data;

endmodule
